aes256_stream_loader: RTL and testbench
=======================================

Name: aes256_stream_loader

Overview:
- Host-side front/back end for the AES-256 encryption core.
- Accepts 32-bit words on a valid/ready input stream and assembles the 256-bit key and 128-bit plaintext block.
- Pulses the core's start, waits a fixed core latency, captures the 128-bit ciphertext, and returns it as four 32-bit words on a valid/ready output stream.
- One block in flight at a time; the key persists across blocks until reloaded.

Parameters:
- CORE_LATENCY, 16, clk cycles from the core_start pulse (cycle 0) to the cycle where core_ciphertext holds the final result; legal range 2..255.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- s_data  input  32  input word
- s_is_key  input  1  1 = word belongs to key, 0 = word belongs to plaintext
- s_valid  input  1  input word valid
- s_ready  output  1  loader accepts word this cycle
- m_data  output  32  ciphertext word
- m_last  output  1  marks 4th ciphertext word
- m_valid  output  1  output word valid
- m_ready  input  1  sink accepts word
- core_key  output  256  to core Key
- core_datain  output  128  to core Datain
- core_start  output  1  one-cycle start pulse to core
- core_ciphertext  input  128  from core CipherText
- key_loaded  output  1  full 256-bit key present
- busy  output  1  high in START, WAIT, OUT

Behaviour:
- Reset (async, rst=1): state=LOAD; key_cnt=0, dat_cnt=0, out_cnt=0; key_loaded=0; core_key=0; core_datain=0; core_start=0; m_valid=0; m_last=0; m_data=0; busy=0.
- Handshake: a word transfers on posedge when valid & ready. m_data/m_last/m_valid are stable while m_valid & !m_ready. s_ready is never a function of s_valid.
- Word order is MSB first:
  - Key word k (0..7) lands in core_key[255-32k -: 32].
  - Data word d (0..3) lands in core_datain[127-32d -: 32].
  - Output word o (0..3) = ciphertext[127-32o -: 32].
- LOAD:
  - s_ready = s_is_key | key_loaded.
  - Accepted key word: written at key_cnt, key_cnt increments.
    - First key word (key_cnt 0) clears key_loaded.
    - On the 8th, key_cnt wraps to 0 and key_loaded=1 (visible next cycle).
  - Accepted data word: written at dat_cnt, dat_cnt increments.
    - On the 4th, dat_cnt wraps to 0 and next state is START.
  - A partial key reload keeps dat_cnt. Data words stall (s_ready=0) until the key is complete again.
- START: core_start=1 for exactly this one cycle; s_ready=0; next state WAIT with lat_cnt=1.
- WAIT:
  - s_ready=0; lat_cnt increments each cycle.
  - When lat_cnt==CORE_LATENCY, capture core_ciphertext into the output buffer, out_cnt=0, next state OUT.
  - core_key and core_datain are held constant from START until OUT.
- OUT:
  - m_valid=1; m_data=word out_cnt; m_last=(out_cnt==3).
  - On handshake, out_cnt increments. After word 3, m_valid=0 and state returns to LOAD the next cycle.
  - s_ready=0 throughout OUT.
- busy=1 in START, WAIT and OUT.
- Reset mid-operation (any state): immediate return to reset values. Partial blocks and keys are discarded, and any pending output word is dropped.
- A key word presented with s_valid while not in LOAD is held off by s_ready=0; it is not lost.
- Back-pressure: m_ready low indefinitely holds OUT; no timeout.

Test Plan:
- FIPS-197 C.3 vector:
  - Stimulus: key words 00010203,04050607,...,1c1d1e1f; data words 00112233,44556677,8899aabb,ccddeeff; m_ready=1.
  - Required: core_start one cycle after the 4th data word; m_data 8ea2b7ca,516745bf,eafc4990,4b496089 with m_last on the 4th word; key_loaded=1.
- Data before key:
  - Stimulus: data word with s_is_key=0 after reset.
  - Required: s_ready=0, no state change; after 8 key words it is accepted.
- Second block, same key:
  - Stimulus: after the C.3 run, send the same plaintext again without key words.
  - Required: identical ciphertext; key_cnt untouched.
- Output back-pressure:
  - Stimulus: m_ready=0 for 10 cycles at word 1.
  - Required: m_data holds 516745bf and m_valid stays 1; s_ready=0 throughout; the sequence resumes unchanged.
- Reset mid-WAIT:
  - Stimulus: rst pulse 3 cycles after core_start.
  - Required: m_valid never asserts; key_loaded=0; busy=0; s_ready asserts only for key words.
- Partial key reload:
  - Stimulus: after a full key, send 3 key words then a data word.
  - Required: key_loaded=0 and the data word is stalled until 5 more key words complete the key.

Source files
------------

// File: rtl/aes256_stream_loader_if.sv
// Host-side word streams of the AES-256 loader: a key/plaintext input stream
// and a ciphertext output stream, both valid/ready.
interface aes256_stream_loader_if;
  logic [31:0] s_data;
  logic        s_is_key;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  modport slave (
    input  s_data, s_is_key, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid
  );

  modport master (
    output s_data, s_is_key, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid
  );
endinterface

// File: rtl/aes256_stream_loader.sv
// Assembles a 256-bit key and 128-bit block from 32-bit words, runs the AES-256
// core for a fixed latency and streams the ciphertext back as four words.
module aes256_stream_loader #(
  parameter int CORE_LATENCY = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  aes256_stream_loader_if.slave host,
  output logic [255:0]          core_key,
  output logic [127:0]          core_datain,
  output logic                  core_start,
  input  logic [127:0]          core_ciphertext,
  output logic                  key_loaded,
  output logic                  busy
);

  typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

  localparam logic [7:0] LAT = 8'(CORE_LATENCY);

  state_t       state;
  logic [2:0]   key_cnt;
  logic [1:0]   dat_cnt;
  logic [1:0]   out_cnt;
  logic [1:0]   out_nxt;
  logic [7:0]   lat_cnt;
  logic [127:0] out_buf;

  // Data words wait for a complete key; nothing is taken outside LOAD.
  assign host.s_ready = (state == LOAD) && (host.s_is_key || key_loaded);
  assign out_nxt      = out_cnt + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      key_cnt      <= '0;
      dat_cnt      <= '0;
      out_cnt      <= '0;
      lat_cnt      <= '0;
      out_buf      <= '0;
      key_loaded   <= 1'b0;
      core_key     <= '0;
      core_datain  <= '0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      host.m_valid <= 1'b0;
      host.m_last  <= 1'b0;
      host.m_data  <= '0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        LOAD: begin
          if (host.s_valid && host.s_ready) begin
            // Word slots are filled MSB first: index 0 lands in the top 32 bits.
            if (host.s_is_key) begin
              core_key[{~key_cnt, 5'b0} +: 32] <= host.s_data;
              key_cnt <= key_cnt + 3'd1;
              if (key_cnt == 3'd7) begin
                key_loaded <= 1'b1;
              end else if (key_cnt == 3'd0) begin
                key_loaded <= 1'b0;
              end
            end else begin
              core_datain[{~dat_cnt, 5'b0} +: 32] <= host.s_data;
              dat_cnt <= dat_cnt + 2'd1;
              if (dat_cnt == 2'd3) begin
                state      <= START;
                core_start <= 1'b1;
                busy       <= 1'b1;
              end
            end
          end
        end
        START: begin
          state   <= WAIT;
          lat_cnt <= 8'd1;
        end
        WAIT: begin
          if (lat_cnt == LAT) begin
            out_buf      <= core_ciphertext;
            out_cnt      <= 2'd0;
            state        <= OUT;
            host.m_valid <= 1'b1;
            host.m_data  <= core_ciphertext[127:96];
            host.m_last  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        OUT: begin
          if (host.m_valid && host.m_ready) begin
            if (out_cnt == 2'd3) begin
              host.m_valid <= 1'b0;
              host.m_last  <= 1'b0;
              state        <= LOAD;
              busy         <= 1'b0;
            end else begin
              out_cnt     <= out_nxt;
              host.m_data <= out_buf[{~out_nxt, 5'b0} +: 32];
              host.m_last <= (out_nxt == 2'd3);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_stream_loader.sv
// Directed bench for aes256_stream_loader using the FIPS-197 C.3 vector and a
// stub core that presents the ciphertext only in the cycle it becomes final.
module tb_aes256_stream_loader;

  localparam int LAT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] core_key;
  logic [127:0] core_datain;
  logic         core_start;
  logic [127:0] core_ciphertext;
  logic         key_loaded;
  logic         busy;

  logic [255:0] key_v = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] pt_v  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] ct_v  = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic [31:0]  key_w [8] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                              32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};
  logic [31:0]  pt_w  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

  int total = 0;
  int bad   = 0;
  int core_cnt;

  always #5 clk = ~clk;

  aes256_stream_loader_if host ();

  aes256_stream_loader #(.CORE_LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .host(host),
    .core_key(core_key),
    .core_datain(core_datain),
    .core_start(core_start),
    .core_ciphertext(core_ciphertext),
    .key_loaded(key_loaded),
    .busy(busy)
  );

  // Stub core: the real result is visible only in cycle LAT after core_start.
  always @(posedge clk or posedge rst) begin
    if (rst) core_cnt <= 0;
    else if (core_start) core_cnt <= 1;
    else if (core_cnt != 0 && core_cnt < 1000) core_cnt <= core_cnt + 1;
  end

  assign core_ciphertext = (core_cnt != LAT) ? 128'hdeadbeef_deadbeef_deadbeef_deadbeef :
                           ((core_key == key_v && core_datain == pt_v) ? ct_v :
                            (core_datain ^ 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a));

  task automatic send_word(input logic [31:0] d, input logic k, output logic ok);
    int n;
    ok = 1'b0;
    n = 0;
    host.s_data = d;
    host.s_is_key = k;
    host.s_valid = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (host.s_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
      n++;
    end
    host.s_valid = 1'b0;
    host.s_is_key = 1'b0;
    if (!ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic collect(input int n, output logic [127:0] words, output logic [3:0] lasts,
                         output int got);
    int cyc;
    words = '0;
    lasts = '0;
    got = 0;
    cyc = 0;
    host.m_ready = 1'b1;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      if (host.m_valid) begin
        words[127 - 32*got -: 32] = host.m_data;
        lasts[got] = host.m_last;
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    host.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host.s_data = '0;
    host.s_is_key = 1'b0;
    host.s_valid = 1'b0;
    host.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (host.m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%0h want=0", host.m_valid); end
    total++; if (host.m_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_last got=%0h want=0", host.m_last); end
    total++; if (host.m_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_m_data got=%h want=0", host.m_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h want=0", busy); end
    total++; if (key_loaded !== 1'b0) begin bad++; $display("[TB] FAIL reset_key_loaded got=%0h want=0", key_loaded); end
    total++; if (core_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_core_start got=%0h want=0", core_start); end
    total++; if (core_key !== 256'h0) begin bad++; $display("[TB] FAIL reset_core_key got=%h want=0", core_key); end
    total++; if (core_datain !== 128'h0) begin bad++; $display("[TB] FAIL reset_core_datain got=%h want=0", core_datain); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_data_before_key();
    int  hits;
    logic ok;
    logic acc;
    hits = 0;
    host.s_data = pt_w[0];
    host.s_is_key = 1'b0;
    host.s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (host.s_ready) hits++;
    end
    host.s_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (hits != 0) begin bad++; $display("[TB] FAIL nokey_s_ready got=%0d want=0", hits); end
    total++; if (core_datain !== 128'h0) begin bad++; $display("[TB] FAIL nokey_datain got=%h want=0", core_datain); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL nokey_busy got=%0h want=0", busy); end
    acc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word(key_w[i], 1'b1, ok);
      acc &= ok;
    end
    total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL nokey_key_accept got=%0h want=1", acc); end
    total++; if (key_loaded !== 1'b1) begin bad++; $display("[TB] FAIL nokey_key_loaded got=%0h want=1", key_loaded); end
    total++; if (core_key !== key_v) begin bad++; $display("[TB] FAIL nokey_core_key got=%h want=%h", core_key, key_v); end
    send_word(pt_w[0], 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL nokey_data_accept got=%0h want=1", ok); end
  endtask

  task automatic test_fips_c3();
    logic         ok;
    logic         acc;
    logic [127:0] words;
    logic [3:0]   lasts;
    int           got;
    acc = 1'b1;
    for (int i = 1; i < 4; i++) begin
      send_word(pt_w[i], 1'b0, ok);
      acc &= ok;
    end
    total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL c3_data_accept got=%0h want=1", acc); end
    total++; if (core_start !== 1'b1) begin bad++; $display("[TB] FAIL c3_core_start got=%0h want=1", core_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL c3_busy_start got=%0h want=1", busy); end
    total++; if (core_datain !== pt_v) begin bad++; $display("[TB] FAIL c3_datain got=%h want=%h", core_datain, pt_v); end
    host.s_is_key = 1'b1;
    #1;
    total++; if (host.s_ready !== 1'b0) begin bad++; $display("[TB] FAIL c3_s_ready_start got=%0h want=0", host.s_ready); end
    host.s_is_key = 1'b0;
    @(posedge clk);
    #1;
    total++; if (core_start !== 1'b0) begin bad++; $display("[TB] FAIL c3_start_pulse got=%0h want=0", core_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL c3_busy_wait got=%0h want=1", busy); end
    collect(4, words, lasts, got);
    total++; if (got != 4) begin bad++; $display("[TB] FAIL c3_count got=%0d want=4", got); end
    total++; if (words !== ct_v) begin bad++; $display("[TB] FAIL c3_cipher got=%h want=%h", words, ct_v); end
    total++; if (lasts !== 4'b1000) begin bad++; $display("[TB] FAIL c3_last got=%b want=1000", lasts); end
    total++; if (host.m_valid !== 1'b0) begin bad++; $display("[TB] FAIL c3_m_valid_end got=%0h want=0", host.m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL c3_busy_end got=%0h want=0", busy); end
    total++; if (key_loaded !== 1'b1) begin bad++; $display("[TB] FAIL c3_key_loaded got=%0h want=1", key_loaded); end
  endtask

  task automatic test_second_block();
    logic         ok;
    logic         acc;
    logic [127:0] words;
    logic [3:0]   lasts;
    int           got;
    acc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(pt_w[i], 1'b0, ok);
      acc &= ok;
    end
    total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL blk2_accept got=%0h want=1", acc); end
    total++; if (core_start !== 1'b1) begin bad++; $display("[TB] FAIL blk2_core_start got=%0h want=1", core_start); end
    collect(4, words, lasts, got);
    total++; if (words !== ct_v) begin bad++; $display("[TB] FAIL blk2_cipher got=%h want=%h", words, ct_v); end
    total++; if (lasts !== 4'b1000) begin bad++; $display("[TB] FAIL blk2_last got=%b want=1000", lasts); end
    total++; if (key_loaded !== 1'b1) begin bad++; $display("[TB] FAIL blk2_key_loaded got=%0h want=1", key_loaded); end
    total++; if (core_key !== key_v) begin bad++; $display("[TB] FAIL blk2_core_key got=%h want=%h", core_key, key_v); end
  endtask

  task automatic test_backpressure();
    logic         ok;
    logic [127:0] words;
    logic [3:0]   lasts;
    int           got;
    int           n;
    for (int i = 0; i < 4; i++) send_word(pt_w[i], 1'b0, ok);
    n = 0;
    host.m_ready = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      if (host.m_valid) break;
      n++;
    end
    total++; if (host.m_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_first_valid got=%0h want=1", host.m_valid); end
    total++; if (host.m_data !== ct_v[127:96]) begin bad++; $display("[TB] FAIL bp_word0 got=%h want=%h", host.m_data, ct_v[127:96]); end
    @(posedge clk);
    #1;
    host.m_ready = 1'b1;
    @(posedge clk);
    #1;
    host.m_ready = 1'b0;
    host.s_data = 32'hcafef00d;
    host.s_is_key = 1'b1;
    host.s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (host.m_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid c=%0d got=%0h want=1", c, host.m_valid); end
      total++; if (host.m_data !== ct_v[95:64]) begin bad++; $display("[TB] FAIL bp_hold_data c=%0d got=%h want=%h", c, host.m_data, ct_v[95:64]); end
      total++; if (host.m_last !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_last c=%0d got=%0h want=0", c, host.m_last); end
      total++; if (host.s_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_s_ready c=%0d got=%0h want=0", c, host.s_ready); end
    end
    host.s_valid = 1'b0;
    host.s_is_key = 1'b0;
    @(posedge clk);
    #1;
    collect(3, words, lasts, got);
    total++; if (words[127:32] !== ct_v[95:0]) begin bad++; $display("[TB] FAIL bp_resume got=%h want=%h", words[127:32], ct_v[95:0]); end
    total++; if (lasts !== 4'b0100) begin bad++; $display("[TB] FAIL bp_last got=%b want=0100", lasts); end
    total++; if (core_key !== key_v) begin bad++; $display("[TB] FAIL bp_core_key got=%h want=%h", core_key, key_v); end
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    int   hits;
    for (int i = 0; i < 4; i++) send_word(pt_w[i], 1'b0, ok);
    total++; if (core_start !== 1'b1) begin bad++; $display("[TB] FAIL rst_core_start got=%0h want=1", core_start); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0h want=0", busy); end
    total++; if (key_loaded !== 1'b0) begin bad++; $display("[TB] FAIL rst_key_loaded got=%0h want=0", key_loaded); end
    total++; if (core_key !== 256'h0) begin bad++; $display("[TB] FAIL rst_core_key got=%h want=0", core_key); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    hits = 0;
    host.m_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (host.m_valid) hits++;
    end
    host.m_ready = 1'b0;
    @(posedge clk);
    #1;
    total++; if (hits != 0) begin bad++; $display("[TB] FAIL rst_m_valid got=%0d want=0", hits); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy_after got=%0h want=0", busy); end
    host.s_is_key = 1'b0;
    #1;
    total++; if (host.s_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_s_ready_data got=%0h want=0", host.s_ready); end
    host.s_is_key = 1'b1;
    #1;
    total++; if (host.s_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_s_ready_key got=%0h want=1", host.s_ready); end
    host.s_is_key = 1'b0;
  endtask

  task automatic test_partial_reload();
    logic         ok;
    logic         acc;
    logic [127:0] words;
    logic [3:0]   lasts;
    int           got;
    int           hits;
    acc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word(key_w[i], 1'b1, ok);
      acc &= ok;
    end
    total++; if (key_loaded !== 1'b1) begin bad++; $display("[TB] FAIL pk_full got=%0h want=1", key_loaded); end
    send_word(pt_w[0], 1'b0, ok);
    acc &= ok;
    for (int i = 0; i < 3; i++) begin
      send_word(key_w[i], 1'b1, ok);
      acc &= ok;
    end
    total++; if (key_loaded !== 1'b0) begin bad++; $display("[TB] FAIL pk_partial got=%0h want=0", key_loaded); end
    hits = 0;
    host.s_data = pt_w[1];
    host.s_is_key = 1'b0;
    host.s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (host.s_ready) hits++;
    end
    host.s_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (hits != 0) begin bad++; $display("[TB] FAIL pk_stall got=%0d want=0", hits); end
    for (int i = 3; i < 8; i++) begin
      send_word(key_w[i], 1'b1, ok);
      acc &= ok;
    end
    total++; if (key_loaded !== 1'b1) begin bad++; $display("[TB] FAIL pk_reloaded got=%0h want=1", key_loaded); end
    for (int i = 1; i < 4; i++) begin
      send_word(pt_w[i], 1'b0, ok);
      acc &= ok;
    end
    total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL pk_accept got=%0h want=1", acc); end
    total++; if (core_start !== 1'b1) begin bad++; $display("[TB] FAIL pk_core_start got=%0h want=1", core_start); end
    total++; if (core_datain !== pt_v) begin bad++; $display("[TB] FAIL pk_datain got=%h want=%h", core_datain, pt_v); end
    collect(4, words, lasts, got);
    total++; if (words !== ct_v) begin bad++; $display("[TB] FAIL pk_cipher got=%h want=%h", words, ct_v); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_data_before_key();
    test_fips_c3();
    test_second_block();
    test_backpressure();
    test_reset_mid_wait();
    test_partial_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
